// File: rtl/vtg_mode_sequencer.sv
// vtg_mode_sequencer
//   Mode controller for the video timing generator. Holds a three-entry mode
//   table (720p, 1080p, 1440p RB), and sequences the following:
//     - PLL-lock bring-up,
//     - frame-aligned mode switches,
//     - timing-register loads,
//     - output muting,
//   so that the pixel path never sees a torn frame or mixed timings.
//
// Ports
//   clk, rst_n            pixel clock, async active-low reset
//   pll_locked            PLL lock, synchronous to clk
//   frame_end             1-cycle pulse on the last pixel of a frame
//   mode_req_valid/_id    mode-change request (id 3 is invalid)
//   mode_req_ready        request consumed on valid && ready (ACTIVE only)
//   mode_err              1-cycle pulse for an accepted id-3 request
//   mode_cur              mode currently loaded
//   busy                  high in every state but ACTIVE
//   cfg_load              1-cycle pulse, timing fields just updated
//   tg_run                timing generator enable (low = counters held at 0)
//   video_mute            force pattern output to black
//   h_*/v_*               timing fields and sync polarities of mode_cur
module vtg_mode_sequencer #(
  parameter int DEFAULT_MODE  = 2,
  parameter int SETTLE_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pll_locked,
  input  logic        frame_end,
  input  logic        mode_req_valid,
  input  logic [1:0]  mode_req_id,
  output logic        mode_req_ready,
  output logic        mode_err,
  output logic [1:0]  mode_cur,
  output logic        busy,
  output logic        cfg_load,
  output logic        tg_run,
  output logic        video_mute,
  output logic [11:0] h_bporch,
  output logic [11:0] h_active,
  output logic [11:0] h_fporch,
  output logic [11:0] h_sync,
  output logic [11:0] h_total,
  output logic [11:0] v_bporch,
  output logic [11:0] v_active,
  output logic [11:0] v_fporch,
  output logic [11:0] v_sync,
  output logic [11:0] v_total,
  output logic        h_polar,
  output logic        v_polar
);

  typedef struct packed {
    logic [11:0] h_bp, h_act, h_fp, h_sy, h_tot;
    logic [11:0] v_bp, v_act, v_fp, v_sy, v_tot;
    logic        h_pol, v_pol;
  } timing_t;

  typedef enum logic [2:0] {
    WAIT_LOCK, LOAD, SETTLE, ACTIVE, DRAIN, STOP
  } state_t;

  function automatic timing_t mode_entry(input logic [1:0] m);
    case (m)
      2'd0:    return '{12'd220, 12'd1280, 12'd110, 12'd40, 12'd1650,
                        12'd20,  12'd720,  12'd5,   12'd5,  12'd750,  1'b1, 1'b1};
      2'd1:    return '{12'd148, 12'd1920, 12'd88,  12'd44, 12'd2200,
                        12'd36,  12'd1080, 12'd4,   12'd5,  12'd1125, 1'b1, 1'b1};
      default: return '{12'd40,  12'd2560, 12'd8,   12'd32, 12'd2640,
                        12'd6,   12'd1440, 12'd13,  12'd8,  12'd1467, 1'b1, 1'b0};
    endcase
  endfunction

  localparam logic [1:0] DEF   = DEFAULT_MODE[1:0];
  localparam logic [3:0] SF    = SETTLE_FRAMES[3:0];
  localparam timing_t    DEF_T = mode_entry(DEF);

  // {tg_run, video_mute, busy, mode_req_ready}, registered on state entry.
  localparam logic [3:0] OUT_IDLE   = 4'b0110;  // WAIT_LOCK, LOAD, STOP
  localparam logic [3:0] OUT_MUTED  = 4'b1110;  // SETTLE, DRAIN
  localparam logic [3:0] OUT_ACTIVE = 4'b1001;

  state_t     state;
  logic [1:0] pend_mode;
  logic [3:0] fcnt;
  timing_t    tmg;
  logic       load_go;

  // Both entries into LOAD (after lock and after STOP) copy the table entry.
  assign load_go = pll_locked && (state == WAIT_LOCK || state == STOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_LOCK;
      pend_mode <= DEF;
      mode_cur  <= DEF;
      fcnt      <= '0;
      tmg       <= DEF_T;
      cfg_load  <= 1'b0;
      mode_err  <= 1'b0;
      {tg_run, video_mute, busy, mode_req_ready} <= OUT_IDLE;
    end else begin
      cfg_load <= 1'b0;
      mode_err <= 1'b0;
      if (!pll_locked && state != WAIT_LOCK) begin
        // Lock loss wins over everything; pend_mode and timing are kept so
        // an interrupted switch resumes after relock.
        state <= WAIT_LOCK;
        {tg_run, video_mute, busy, mode_req_ready} <= OUT_IDLE;
      end else begin
        if (load_go) begin
          state    <= LOAD;
          tmg      <= mode_entry(pend_mode);
          mode_cur <= pend_mode;
          cfg_load <= 1'b1;
          {tg_run, video_mute, busy, mode_req_ready} <= OUT_IDLE;
        end
        case (state)
          LOAD: begin
            fcnt <= '0;
            if (SF == 4'd0) begin
              state <= ACTIVE;
              {tg_run, video_mute, busy, mode_req_ready} <= OUT_ACTIVE;
            end else begin
              state <= SETTLE;
              {tg_run, video_mute, busy, mode_req_ready} <= OUT_MUTED;
            end
          end
          SETTLE: if (frame_end) begin
            if (fcnt + 4'd1 == SF) begin
              state <= ACTIVE;
              {tg_run, video_mute, busy, mode_req_ready} <= OUT_ACTIVE;
            end
            fcnt <= fcnt + 4'd1;
          end
          ACTIVE: if (mode_req_valid && mode_req_ready) begin
            // frame_end here is deliberately ignored: DRAIN waits for the
            // next full frame boundary.
            if (mode_req_id == 2'd3) begin
              mode_err <= 1'b1;
            end else if (mode_req_id != mode_cur) begin
              pend_mode <= mode_req_id;
              state     <= DRAIN;
              {tg_run, video_mute, busy, mode_req_ready} <= OUT_MUTED;
            end
          end
          DRAIN: if (frame_end) begin
            state <= STOP;
            {tg_run, video_mute, busy, mode_req_ready} <= OUT_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign h_bporch = tmg.h_bp;
  assign h_active = tmg.h_act;
  assign h_fporch = tmg.h_fp;
  assign h_sync   = tmg.h_sy;
  assign h_total  = tmg.h_tot;
  assign v_bporch = tmg.v_bp;
  assign v_active = tmg.v_act;
  assign v_fporch = tmg.v_fp;
  assign v_sync   = tmg.v_sy;
  assign v_total  = tmg.v_tot;
  assign h_polar  = tmg.h_pol;
  assign v_polar  = tmg.v_pol;

endmodule

// File: tb/tb_vtg_mode_sequencer.sv
// Bench for vtg_mode_sequencer: directed stimulus, a phase-level reference
// model compared on every falling edge, and literal spot checks.
module tb_vtg_mode_sequencer;
  localparam int SF = 2;
  localparam int P_WAIT = 0, P_LOAD = 1, P_SETTLE = 2, P_ACTIVE = 3, P_DRAIN = 4, P_STOP = 5;

  // Mode table in bench form: BP, ACT, FP, SYNC; totals are summed here.
  int hf [3][4] = '{'{220, 1280, 110, 40}, '{148, 1920, 88, 44}, '{40, 2560, 8, 32}};
  int vf [3][4] = '{'{20, 720, 5, 5},      '{36, 1080, 4, 5},    '{6, 1440, 13, 8}};
  int hp [3]    = '{1, 1, 1};
  int vp [3]    = '{1, 1, 0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pll_locked = 1'b0, frame_end = 1'b0, mode_req_valid = 1'b0;
  logic [1:0] mode_req_id = 2'd0;
  always #5 clk = ~clk;

  logic mode_req_ready, mode_err, busy, cfg_load, tg_run, video_mute, h_polar, v_polar;
  logic [1:0] mode_cur;
  logic [11:0] h_bporch, h_active, h_fporch, h_sync, h_total;
  logic [11:0] v_bporch, v_active, v_fporch, v_sync, v_total;

  logic z_ready, z_err, z_busy, z_cfg, z_run, z_mute, z_hpol, z_vpol;
  logic [1:0] z_cur;
  logic [11:0] z_hbp, z_hact, z_hfp, z_hsy, z_htot, z_vbp, z_vact, z_vfp, z_vsy, z_vtot;

  vtg_mode_sequencer #(.DEFAULT_MODE(2), .SETTLE_FRAMES(SF)) u_dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .frame_end(frame_end),
    .mode_req_valid(mode_req_valid), .mode_req_id(mode_req_id),
    .mode_req_ready(mode_req_ready), .mode_err(mode_err), .mode_cur(mode_cur),
    .busy(busy), .cfg_load(cfg_load), .tg_run(tg_run), .video_mute(video_mute),
    .h_bporch(h_bporch), .h_active(h_active), .h_fporch(h_fporch), .h_sync(h_sync),
    .h_total(h_total), .v_bporch(v_bporch), .v_active(v_active), .v_fporch(v_fporch),
    .v_sync(v_sync), .v_total(v_total), .h_polar(h_polar), .v_polar(v_polar));

  vtg_mode_sequencer #(.DEFAULT_MODE(2), .SETTLE_FRAMES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .frame_end(frame_end),
    .mode_req_valid(mode_req_valid), .mode_req_id(mode_req_id),
    .mode_req_ready(z_ready), .mode_err(z_err), .mode_cur(z_cur),
    .busy(z_busy), .cfg_load(z_cfg), .tg_run(z_run), .video_mute(z_mute),
    .h_bporch(z_hbp), .h_active(z_hact), .h_fporch(z_hfp), .h_sync(z_hsy),
    .h_total(z_htot), .v_bporch(z_vbp), .v_active(z_vact), .v_fporch(z_vfp),
    .v_sync(z_vsy), .v_total(z_vtot), .h_polar(z_hpol), .v_polar(z_vpol));

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: which phase of the sequence we are in, plus the pending
  // and loaded mode. Timing fields are always the table entry of m_cur.
  int ph = P_WAIT, m_pend = 2, m_cur = 2, m_cnt = 0;
  logic m_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= P_WAIT; m_pend <= 2; m_cur <= 2; m_cnt <= 0; m_err <= 1'b0;
    end else begin
      m_err <= 1'b0;
      if (!pll_locked) ph <= P_WAIT;
      else case (ph)
        P_WAIT, P_STOP: begin ph <= P_LOAD; m_cur <= m_pend; end
        P_LOAD: begin ph <= (SF == 0) ? P_ACTIVE : P_SETTLE; m_cnt <= 0; end
        P_SETTLE: if (frame_end) begin
          if (m_cnt + 1 >= SF) ph <= P_ACTIVE;
          m_cnt <= m_cnt + 1;
        end
        P_ACTIVE: if (mode_req_valid) begin
          if (mode_req_id == 2'd3) m_err <= 1'b1;
          else if (int'(mode_req_id) != m_cur) begin m_pend <= int'(mode_req_id); ph <= P_DRAIN; end
        end
        P_DRAIN: if (frame_end) ph <= P_STOP;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    check("cfg_load", cfg_load, ph == P_LOAD);
    check("tg_run", tg_run, ph == P_SETTLE || ph == P_ACTIVE || ph == P_DRAIN);
    check("video_mute", video_mute, ph != P_ACTIVE);
    check("busy", busy, ph != P_ACTIVE);
    check("mode_req_ready", mode_req_ready, ph == P_ACTIVE);
    check("mode_err", mode_err, m_err);
    check("mode_cur", mode_cur, m_cur);
    check("h_bporch", h_bporch, hf[m_cur][0]);
    check("h_active", h_active, hf[m_cur][1]);
    check("h_fporch", h_fporch, hf[m_cur][2]);
    check("h_sync", h_sync, hf[m_cur][3]);
    check("h_total", h_total, hf[m_cur][0] + hf[m_cur][1] + hf[m_cur][2] + hf[m_cur][3]);
    check("v_bporch", v_bporch, vf[m_cur][0]);
    check("v_active", v_active, vf[m_cur][1]);
    check("v_fporch", v_fporch, vf[m_cur][2]);
    check("v_sync", v_sync, vf[m_cur][3]);
    check("v_total", v_total, vf[m_cur][0] + vf[m_cur][1] + vf[m_cur][2] + vf[m_cur][3]);
    check("h_polar", h_polar, hp[m_cur]);
    check("v_polar", v_polar, vp[m_cur]);
  end

  int cfg_cnt = 0;
  always @(posedge clk) if (cfg_load) cfg_cnt <= cfg_cnt + 1;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_fe();
    frame_end = 1'b1; tick(); frame_end = 1'b0;
  endtask

  task automatic request(input logic [1:0] id);
    mode_req_valid = 1'b1; mode_req_id = id; tick(); mode_req_valid = 1'b0;
  endtask

  initial begin
    int bad, c0;
    // Reset state
    tick(3);
    check("rst tg_run", tg_run, 0);
    check("rst video_mute", video_mute, 1);
    check("rst busy", busy, 1);
    check("rst ready", mode_req_ready, 0);
    check("rst h_total", h_total, 2640);
    rst_n = 1'b1;

    // Lock held low for 100 cycles
    bad = 0;
    repeat (100) begin tick(); if (tg_run || !video_mute) bad++; end
    check("unlocked run/mute", bad, 0);
    pll_locked = 1'b1; tick();
    check("lock cfg_load", cfg_load, 1);
    check("lock h_total", h_total, 2640);
    check("lock v_total", v_total, 1467);
    check("lock v_polar", v_polar, 0);
    tick();
    check("sf0 active mute", z_mute, 0);
    check("sf0 active busy", z_busy, 0);
    check("settle tg_run", tg_run, 1);
    tick(5); pulse_fe();
    check("one frame still muted", video_mute, 1);
    tick(5); pulse_fe();
    check("unmute after 2nd frame", video_mute, 0);
    tick(3);

    // Invalid and no-op requests
    c0 = cfg_cnt;
    request(2'd3);
    check("err pulse", mode_err, 1);
    check("err busy", busy, 0);
    tick();
    check("err one cycle", mode_err, 0);
    request(2'd2);
    check("noop busy", busy, 0);
    check("noop mute", video_mute, 0);
    tick(3);
    check("no cfg_load", cfg_cnt - c0, 0);

    // Switch to 720p with a long drain
    request(2'd0);
    check("switch mute", video_mute, 1);
    check("switch ready", mode_req_ready, 0);
    bad = 0;
    repeat (500) begin tick(); if (!video_mute) bad++; end
    check("drain mute held", bad, 0);
    pulse_fe();
    check("stop tg_run", tg_run, 0);
    tick();
    check("720 cfg_load", cfg_load, 1);
    check("720 h_active", h_active, 1280);
    check("720 v_total", v_total, 750);
    check("720 mode_cur", mode_cur, 0);
    tick(); pulse_fe(); tick(2); pulse_fe(); tick(2);

    // Lock loss mid-switch
    request(2'd1);
    tick(3);
    pll_locked = 1'b0; tick();
    check("lost tg_run", tg_run, 0);
    check("lost busy", busy, 1);
    bad = 0;
    repeat (50) begin tick(); if (tg_run) bad++; end
    check("lost tg_run held", bad, 0);
    pll_locked = 1'b1; tick();
    check("relock cfg_load", cfg_load, 1);
    check("relock h_total", h_total, 2200);
    check("relock mode_cur", mode_cur, 1);
    tick(); pulse_fe(); tick(2); pulse_fe(); tick(2);

    // Backpressure during SETTLE
    request(2'd2);
    tick(); pulse_fe();
    mode_req_valid = 1'b1; mode_req_id = 2'd0;
    tick(2);
    bad = 0;
    repeat (4) begin if (mode_req_ready) bad++; tick(); end
    pulse_fe(); tick(2);
    check("settle ready low", bad + int'(mode_req_ready), 0);
    pulse_fe();
    check("first active ready", mode_req_ready, 1);
    tick(); mode_req_valid = 1'b0;
    check("bp handshake mute", video_mute, 1);
    check("bp handshake ready", mode_req_ready, 0);
    tick(2); pulse_fe(); tick(2); pulse_fe(); tick(2); pulse_fe(); tick(2);
    check("final mode_cur", mode_cur, 0);
    check("final h_total", h_total, 1650);
    check("final mute", video_mute, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
